// File: rtl/uart_tx_stim.sv
// ============================================================================
// uart_tx_stim : 8N1 UART serializer with a small byte FIFO (stimulus/loopback)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_tx_stim #(
  parameter int CLK_FREQ_HZ = 1_600_000,
  parameter int BAUD_RATE   = 100_000,
  parameter int FIFO_DEPTH  = 4,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_sent,
  output logic [4:0] fifo_count
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [4:0]    DEPTH_CNT = 5'(FIFO_DEPTH);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e        state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic          stop_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          busy_q;
  logic          sent_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [4:0]    count_q;
  logic [4:0]    count_d;

  logic          w_push;
  logic          w_pop;
  logic          w_bit_end;
  logic          w_frame_end;
  logic [7:0]    w_head;

  // Push is gated only by registered fullness, so a full FIFO refuses even when popping.
  assign w_push      = in_valid && (count_q != DEPTH_CNT);
  assign w_bit_end   = (baud_q == BAUD_LAST);
  assign w_frame_end = (state_q == S_STOP) && w_bit_end && (stop_q == STOP_LAST);
  assign w_pop       = (count_q != 5'd0) && ((state_q == S_IDLE) || w_frame_end);
  assign w_head      = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      stop_q  <= 1'b0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      sent_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_pop) begin
            shift_q <= w_head;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            baud_q  <= '0;
            bit_q   <= 3'd0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              stop_q  <= 1'b0;
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            baud_q <= '0;
            if (stop_q == STOP_LAST) begin
              sent_q <= 1'b1;
              // Chain straight into the next start bit when a byte is already queued.
              if (w_pop) begin
                shift_q <= w_head;
                tx_q    <= 1'b0;
                state_q <= S_START;
              end else begin
                tx_q    <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end else begin
              stop_q <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = (count_q != DEPTH_CNT);
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_sent = sent_q;
  assign fifo_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_stim.sv
// ============================================================================
// tb_uart_tx_stim : directed self-checking bench for uart_tx_stim
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_stim;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data, in_data2;
  logic       in_valid, in_valid2;
  logic       in_ready, tx, busy, frame_sent;
  logic       in_ready2, tx2, busy2, frame_sent2;
  logic [4:0] fifo_count, fifo_count2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_stim u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .frame_sent (frame_sent),
    .fifo_count (fifo_count)
  );

  uart_tx_stim #(.STOP_BITS(2)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data2),
    .in_valid   (in_valid2),
    .in_ready   (in_ready2),
    .tx         (tx2),
    .busy       (busy2),
    .frame_sent (frame_sent2),
    .fifo_count (fifo_count2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge; the byte is pushed at the next edge.
  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~b;
  endtask

  // Entered at cycle `skip` of a frame (cycle 0 = first cycle tx shows the start bit).
  task automatic watch_frame(input string nm, input logic [7:0] b, input int skip,
                             input bit do_push, input logic [7:0] pb);
    logic [9:0] line;
    int errs [10];
    int ctl;
    line = {1'b1, b, 1'b0};
    ctl  = 0;
    for (int i = 0; i < 10; i++) errs[i] = 0;
    for (int c = skip; c < 160; c++) begin
      if (tx !== line[c/16]) errs[c/16]++;
      if (busy !== 1'b1) ctl++;
      if (c != 0 && frame_sent !== 1'b0) ctl++;
      if (do_push && c == 159) begin
        in_valid = 1'b1;
        in_data  = pb;
      end
      @(posedge clk); #1;
    end
    if (do_push) begin
      in_valid = 1'b0;
      in_data  = ~pb;
    end
    for (int i = 0; i < 10; i++) check_val($sformatf("%s bit%0d", nm, i), errs[i], 0);
    check_val({nm, " busy/pulse"}, ctl, 0);
    check_val({nm, " frame_sent"}, frame_sent, 1);
  endtask

  initial begin : main
    logic [7:0] seq [5];
    int t0, idle_err, line_err, ctl_err;
    seq[0] = 8'hA5; seq[1] = 8'h3C; seq[2] = 8'h06; seq[3] = 8'hFF; seq[4] = 8'h81;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_valid2 = 1'b0; in_data2 = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("reset tx", tx, 1);
    check_val("reset busy", busy, 0);
    check_val("reset frame_sent", frame_sent, 0);
    check_val("reset count", fifo_count, 0);
    check_val("reset in_ready", in_ready, 1);

    // Single byte with one-cycle latency
    push(8'h06);
    check_val("single pre tx", tx, 1);
    check_val("single count1", fifo_count, 1);
    @(posedge clk); #1;
    check_val("single start tx", tx, 0);
    check_val("single count0", fifo_count, 0);
    watch_frame("single", 8'h06, 0, 1'b0, 8'h00);
    check_val("single idle tx", tx, 1);
    check_val("single busy fall", busy, 0);
    @(posedge clk); #1;
    check_val("single pulse end", frame_sent, 0);
    repeat (5) @(posedge clk); #1;

    // Back-to-back with in_valid held high into a full FIFO
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = seq[i];
      check_val($sformatf("b2b ready%0d", i), in_ready, 1);
      @(posedge clk); #1;
    end
    t0 = cyc - 3;
    check_val("b2b full count", fifo_count, 4);
    check_val("b2b full ready", in_ready, 0);
    check_val("b2b busy", busy, 1);
    in_data = 8'hEE;
    repeat (20) @(posedge clk); #1;
    check_val("b2b refused count", fifo_count, 4);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      watch_frame($sformatf("b2b f%0d", i), seq[i], (i == 0) ? 23 : 0, 1'b0, 8'h00);
      check_val($sformatf("b2b count after f%0d", i), fifo_count, (i < 4) ? (3 - i) : 0);
      check_val($sformatf("b2b tx after f%0d", i), tx, (i < 4) ? 0 : 1);
    end
    check_val("b2b total clocks", cyc - t0, 800);
    check_val("b2b busy end", busy, 0);
    repeat (5) @(posedge clk); #1;

    // Pattern pair 0x60, 0x06 contiguous
    push(8'h60);
    push(8'h06);
    check_val("pat count", fifo_count, 1);
    watch_frame("pat 60", 8'h60, 0, 1'b0, 8'h00);
    watch_frame("pat 06", 8'h06, 0, 1'b0, 8'h00);
    check_val("pat idle", tx, 1);
    repeat (5) @(posedge clk); #1;

    // Reset during data bit 3 of 0x55 with two bytes queued
    push(8'h55);
    push(8'hAA);
    push(8'h0F);
    repeat (69) @(posedge clk); #1;
    check_val("rst pre tx bit3", tx, 0);
    check_val("rst pre count", fifo_count, 2);
    #3 rst_n = 1'b0;
    #1;
    check_val("rst async tx", tx, 1);
    check_val("rst async busy", busy, 0);
    check_val("rst async count", fifo_count, 0);
    check_val("rst async ready", in_ready, 1);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    idle_err = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0 || frame_sent !== 1'b0 || fifo_count !== 5'd0) idle_err++;
    end
    check_val("rst stays idle", idle_err, 0);
    push(8'hC3);
    @(posedge clk); #1;
    watch_frame("rst new", 8'hC3, 0, 1'b0, 8'h00);
    repeat (5) @(posedge clk); #1;

    // Push coinciding with pop at the end of STOP
    push(8'h3C);
    push(8'hC3);
    check_val("sim count pre", fifo_count, 1);
    watch_frame("sim X", 8'h3C, 0, 1'b1, 8'h5A);
    check_val("sim count same", fifo_count, 1);
    check_val("sim no gap", tx, 0);
    watch_frame("sim Y", 8'hC3, 0, 1'b0, 8'h00);
    watch_frame("sim Z", 8'h5A, 0, 1'b0, 8'h00);
    check_val("sim end count", fifo_count, 0);
    check_val("sim end busy", busy, 0);

    // Two stop bits on the second instance
    in_valid2 = 1'b1; in_data2 = 8'h00;
    @(posedge clk); #1;
    in_valid2 = 1'b0; in_data2 = 8'hFF;
    @(posedge clk); #1;
    line_err = 0; ctl_err = 0;
    for (int c = 0; c < 176; c++) begin
      if (tx2 !== ((c < 144) ? 1'b0 : 1'b1)) line_err++;
      if (busy2 !== 1'b1 || frame_sent2 !== 1'b0) ctl_err++;
      @(posedge clk); #1;
    end
    check_val("stop2 line", line_err, 0);
    check_val("stop2 ctrl", ctl_err, 0);
    check_val("stop2 frame_sent", frame_sent2, 1);
    check_val("stop2 busy fall", busy2, 0);
    check_val("stop2 tx idle", tx2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_stim.md
Name: uart_tx_stim

Overview:
- 8N1 UART serializer that drives the serial line into the receive/pattern-detect top (its `rx` input).
- Used as the on-chip stimulus source and as the loopback driver in system benches.
- Accepts bytes over a valid/ready handshake into a small FIFO.
- Emits frames back-to-back, LSB first, at the same CLK_FREQ_HZ/BAUD_RATE ratio as the receiver.

Parameters:
- CLK_FREQ_HZ, 1_600_000, system clock frequency in Hz.
- BAUD_RATE, 100_000, line rate in bits/s. DIV = CLK_FREQ_HZ/BAUD_RATE (integer, truncated) clocks per bit; default DIV = 16; DIV >= 2 required.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, 2..16.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  byte to transmit.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept; a push occurs on a rising edge where in_valid & in_ready.
- tx  out  1  serial line, idle high; connects to receiver rx.
- busy  out  1  high while a frame is on the line (start, data or stop).
- frame_sent  out  1  one-cycle pulse on completion of each frame's last stop bit.
- fifo_count  out  5  bytes currently held in FIFO, 0..FIFO_DEPTH.

Behaviour:
- Reset (asynchronous, immediate):
  - tx=1, busy=0, frame_sent=0.
  - FIFO flushed: fifo_count=0, in_ready=1.
  - FSM=IDLE, bit and baud counters cleared.
  - A frame in progress is abandoned; tx returns high at once, with no partial stop bit.
- FIFO:
  - in_ready = (fifo_count != FIFO_DEPTH). It is registered-state derived and does not depend on in_valid.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle with the FIFO not full: fifo_count unchanged, data order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: tx=1, busy=0. If fifo_count>0 at an edge: pop head into shift register, go to START, drive tx=0, busy=1 after that edge.
  - A byte pushed at edge k into an empty FIFO while IDLE produces tx=0 after edge k+1, i.e. one cycle of latency.
  - START: hold tx=0 for DIV clocks, then go to DATA with bit index 0.
  - DATA: drive tx = shift[0] for DIV clocks, then shift right and increment bit index. After bit index 7 completes, go to STOP.
  - STOP: drive tx=1 for STOP_BITS*DIV clocks.
- Frame completion:
  - frame_sent=1 for exactly the one cycle following the edge that ends STOP.
  - At that same edge, if fifo_count>0 (including a byte pushed at that edge? no, only bytes present before that edge), pop the next byte and go straight to START with no idle gap. Otherwise go to IDLE.
  - Frame length: (1+8+STOP_BITS)*DIV clocks. Default is 160 clocks.
- Baud counter:
  - Counts 0..DIV-1 within each bit and restarts at each bit boundary.
  - Free of drift: each bit lasts exactly DIV clocks.
- in_data is sampled only at push; later changes to in_data do not affect queued bytes.
- in_valid held high with in_ready low: no push, no state change. The source must hold in_data stable.
- tx is a registered output, glitch-free.

Test Plan:
- **Single byte:** push 0x06 at reset-idle.
  - tx low 1 cycle after push.
  - Line sequence 0,0,1,1,0,0,0,0,0,1, each bit 16 clocks.
  - frame_sent pulse 160 clocks after start-bit onset; busy falls with it.
- **Back-to-back / full:** push 0xA5,0x3C,0x06,0xFF,0x81 with in_valid held high.
  - Fourth byte accepted while the first is transmitting; in_ready low while fifo_count=4.
  - All 5 frames contiguous: 800 clocks, no idle cycle between stop and start.
  - Receiver shift_window matches each byte in order.
- **Loopback into receiver top** (ID_LAST_DIGIT=6): send 0x60 then 0x06.
  - Receiver match pulses at every bit where the last 4 received bits equal 4'b0110.
  - Receiver framing_error stays 0 throughout.
- **STOP_BITS=2:** push 0x00.
  - Frame is 176 clocks; tx high for the final 32 clocks.
  - frame_sent pulse at clock 176.
- **Reset mid-frame:** assert rst_n=0 during data bit 3 of 0x55 with 2 bytes queued.
  - tx=1, busy=0, fifo_count=0 immediately.
  - After release, no frame is emitted until a new push.
- **Simultaneous push/pop:** fifo_count=1, push at the edge the STOP state ends.
  - fifo_count stays 1.
  - Popped byte is the older one; the pushed byte is transmitted next.
